// File: rtl/mnemonic_pkg.sv
// Shared constants and player state for the mnemonic recorder/player pair.
// Sequence memory holds one level duration (in clocks) per entry.
package mnemonic_pkg;

    localparam int DEPTH = 32;
    localparam int CNT_W = 32;
    localparam int IDX_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_RUN,
        S_FINISH
    } player_state_e;

    function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len);
        if (len > IDX_W'(DEPTH)) return IDX_W'(DEPTH);
        return len;
    endfunction

endpackage

// File: rtl/duration_counter.sv
// Down-counter holding the remaining cycles of the current level.
// A stored duration of zero is played as a single cycle.
module duration_counter
    import mnemonic_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last cycle of the current level
    assign expire_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mnemonic_player.sv
// Replays a recorded list of level durations as a toggling waveform.
// rd_data always carries the entry at ptr_q while RUN/LOAD are active.
module mnemonic_player
    import mnemonic_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IDX_W-1:0] len_i,
    output logic [IDX_W-2:0] rd_addr_o,
    input  logic [CNT_W-1:0] rd_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sequence_o
);

    player_state_e state_q;
    player_state_e state_d;

    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] n_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             seq_q;
    logic             seq_d;

    logic             expire;
    logic             more;
    logic             cut;
    logic             accept;
    logic             load;
    logic [IDX_W-1:0] addr_raw;
    logic [IDX_W-1:0] addr_clip;
    logic             addr_unused;

    assign cut    = abort_i && (state_q != S_IDLE);
    assign accept = (state_q == S_IDLE) && start_i && (len_i != '0);
    assign more   = ptr_q < n_q;
    assign load   = (state_q == S_LOAD)
                 || (state_q == S_RUN && expire && more && !abort_i);

    duration_counter u_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .load_val_i (rd_data_i),
        .en_i       (state_q == S_RUN),
        .expire_o   (expire)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cut) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = (len_i == '0) ? S_FINISH : S_PRIME;
                    end
                end
                S_PRIME:  state_d = S_LOAD;
                S_LOAD:   state_d = S_RUN;
                S_RUN: begin
                    if (expire && !more) state_d = S_FINISH;
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            S_PRIME, S_LOAD, S_RUN: busy_o = 1'b1;
            S_FINISH:               done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        n_d   = n_q;
        ptr_d = ptr_q;
        seq_d = seq_q;
        if (cut) begin
            seq_d = 1'b0;
        end else if (accept) begin
            n_d   = clamp_len(len_i);
            ptr_d = '0;
            seq_d = 1'b0;
        end else if (state_q == S_LOAD) begin
            ptr_d = ptr_q + IDX_W'(1);
        end else if (state_q == S_RUN && expire) begin
            seq_d = ~seq_q;
            if (more) ptr_d = ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            n_q   <= '0;
            ptr_q <= '0;
            seq_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            ptr_q <= ptr_d;
            seq_q <= seq_d;
        end
    end

    // Fetch one ahead on every load so a 1-cycle entry still finds its
    // successor on rd_data; the address is pinned at n-1 past the end.
    assign addr_raw  = load ? ptr_q + IDX_W'(1) : ptr_q;
    assign addr_clip = (n_q != '0 && addr_raw >= n_q) ? n_q - IDX_W'(1)
                                                      : addr_raw;
    assign {addr_unused, rd_addr_o} = addr_clip;

    assign sequence_o = seq_q;

endmodule

// File: tb/tb_mnemonic_player.sv
// Bench for mnemonic_player: directed table, abort/reset/len corner cases
// and random duration lists checked against a cumulative-sum model.
`timescale 1ns/1ps
module tb_mnemonic_player;
    import mnemonic_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] len;
    logic [IDX_W-2:0] rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             seq;

    logic [CNT_W-1:0] mem [DEPTH];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    mnemonic_player dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .abort_i    (abort),
        .len_i      (len),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .busy_o     (busy),
        .done_o     (done),
        .sequence_o (seq)
    );

    typedef struct {
        int len;
        int d [4];
        int done_off;
        int final_lvl;
    } vec_t;

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
    endtask

    task automatic start_cmd(input int l);
        start = 1'b1;
        len   = IDX_W'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Model: level flips once each cumulative duration has elapsed from P (c=3).
    task automatic run_play(input int l, input int restart_c,
                            output int done_c, output int max_addr);
        int n;
        int total;
        int tog;
        int lim;
        int cum [DEPTH];
        n = (l > DEPTH) ? DEPTH : l;
        total = 0;
        for (int i = 0; i < n; i++) begin
            total += (mem[i] == '0) ? 1 : int'(mem[i]);
            cum[i] = total;
        end
        done_c   = -1;
        max_addr = 0;
        start_cmd(l);
        lim = total + 6;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            start = 1'b0;
            tog = 0;
            for (int i = 0; i < n; i++) if (c - 3 >= cum[i]) tog++;
            chk("busy", c, int'(busy), int'(c < 3 + total));
            chk("done", c, int'(done), int'(c == 3 + total));
            chk("sequence", c, int'(seq), tog % 2);
            if (done && done_c < 0) done_c = c;
            if (busy) begin
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                chk("rd_addr_in_range", c, int'(int'(rd_addr) <= n - 1), 1);
            end
            if (c == restart_c) begin
                start = 1'b1;
                len   = IDX_W'(5);
            end
        end
    endtask

    task automatic cut_run(input int at_c, input bit use_reset, input int seq_before);
        mem[0] = 10;
        mem[1] = 10;
        start_cmd(2);
        for (int c = 1; c <= at_c; c++) @(negedge clk);
        chk("seq_before_cut", at_c, int'(seq), seq_before);
        chk("busy_before_cut", at_c, int'(busy), 1);
        if (use_reset) reset = 1'b1;
        else abort = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        for (int c = at_c + 1; c <= at_c + 4; c++) begin
            @(negedge clk);
            chk("busy_after_cut", c, int'(busy), 0);
            chk("done_after_cut", c, int'(done), 0);
            chk("seq_after_cut", c, int'(seq), 0);
            if (use_reset) chk("rd_addr_after_reset", c, int'(rd_addr), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int dc;
        int ma;
        int a0;

        vecs[0] = '{len: 3, d: '{3, 5, 2, 0}, done_off: 10, final_lvl: 1};
        vecs[1] = '{len: 4, d: '{1, 1, 1, 1}, done_off: 4,  final_lvl: 0};
        vecs[2] = '{len: 2, d: '{0, 4, 0, 0}, done_off: 5,  final_lvl: 0};
        vecs[3] = '{len: 1, d: '{7, 0, 0, 0}, done_off: 7,  final_lvl: 1};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        len   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_seq", 0, int'(seq), 0);
        chk("reset_busy", 0, int'(busy), 0);
        chk("reset_done", 0, int'(done), 0);
        chk("reset_rd_addr", 0, int'(rd_addr), 0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = CNT_W'(vecs[v].d[i]);
            run_play(vecs[v].len, -1, dc, ma);
            chk("table_done_offset", v, dc - 3, vecs[v].done_off);
            chk("table_final_level", v, int'(seq), vecs[v].final_lvl);
        end

        // len=0: immediate done, no busy, level and address untouched
        a0 = int'(rd_addr);
        start_cmd(0);
        @(negedge clk);
        chk("len0_done", 1, int'(done), 1);
        chk("len0_busy", 1, int'(busy), 0);
        chk("len0_seq", 1, int'(seq), 1);
        chk("len0_rd_addr", 1, int'(rd_addr), a0);
        @(negedge clk);
        chk("len0_done", 2, int'(done), 0);
        chk("len0_busy", 2, int'(busy), 0);
        chk("len0_rd_addr", 2, int'(rd_addr), a0);

        // len clamped to DEPTH, with a start issued mid-run
        for (int i = 0; i < DEPTH; i++) mem[i] = CNT_W'($urandom_range(0, 2));
        run_play(40, 20, dc, ma);
        chk("len40_max_rd_addr", 0, ma, DEPTH - 1);

        cut_run(7, 1'b0, 0);
        cut_run(14, 1'b0, 1);
        cut_run(15, 1'b1, 1);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = CNT_W'($urandom_range(0, 6));
            run_play(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)), dc, ma);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
